// File: rtl/aes_uart_pkg.sv
// ============================================================================
// Module : aes_uart_pkg
// Brief  : Widths and FSM state encoding shared by the AES UART SIPO/PISO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_uart_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int N_BYTES = BLOCK_W / BYTE_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

`default_nettype wire

// File: rtl/aes_piso_tx.sv
// ============================================================================
// Module : aes_piso_tx
// Brief  : Serialises one AES block MSB-byte-first onto a valid/ready stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_piso_tx
  import aes_uart_pkg::*;
#(
  parameter int DATA_W = aes_uart_pkg::BLOCK_W,
  parameter int BYTE_W = aes_uart_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              done
);

  localparam int N_BYTES = DATA_W / BYTE_W;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_BYTES - 1);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_xfer;

  assign w_xfer = tx_valid_q & tx_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (w_xfer && (cnt_q == C_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (load) begin
          shreg_d    = parallel_in;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (cnt_q == C_LAST) begin
            // Last byte stays in the shifter so tx_data holds it while idle
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            shreg_d = shreg_q << BYTE_W;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = shreg_q[DATA_W-1 -: BYTE_W];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_piso_tx.sv
// ============================================================================
// Module : tb_aes_piso_tx
// Brief  : Directed self-checking bench for aes_piso_tx with a SIPO loopback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_piso_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [127:0] parallel_in = '0;
  logic         tx_ready = 1'b0;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK_A  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_B  = 128'h1122334455667788_99AABBCCDDEEFF00;
  localparam logic [127:0] BLK_A5 = {16{8'hA5}};

  aes_piso_tx dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .parallel_in(parallel_in),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Receive-side SIPO model fed from the transmit stream
  logic [127:0] sipo_q = '0;
  int           sipo_cnt = 0;
  logic         sipo_en = 1'b0;
  logic         sipo_clr = 1'b0;

  always @(posedge clk) begin
    if (sipo_clr) begin
      sipo_q   <= '0;
      sipo_cnt <= 0;
    end else if (sipo_en && tx_valid && tx_ready) begin
      sipo_q   <= {sipo_q[119:0], tx_data};
      sipo_cnt <= sipo_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name, input logic exp_done, input logic [7:0] exp_data);
    chk({name, ".valid"}, 128'(tx_valid), 128'(1'b0));
    chk({name, ".busy"},  128'(busy),     128'(1'b0));
    chk({name, ".done"},  128'(done),     128'(exp_done));
    chk({name, ".data"},  128'(tx_data),  128'(exp_data));
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] blk, input int idx);
    return blk[127 - 8*idx -: 8];
  endfunction

  // Called at a falling edge: request capture of blk on the next rising edge
  task automatic start(input logic [127:0] blk);
    load        = 1'b1;
    parallel_in = blk;
    tx_ready    = 1'b1;
  endtask

  // mode 0: full rate, 1: backpressure, 2: load while busy, 3: reset at byte 9
  task automatic drain(input logic [127:0] blk, input int mode,
                       input bit load_next, input logic [127:0] next_blk);
    int  idx   = 0;
    int  cyc   = 0;
    int  stall = 0;
    bit  alt   = 1'b1;
    logic rdy;
    while (idx < 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      load = 1'b0;
      chk($sformatf("m%0d.valid[%0d]", mode, idx), 128'(tx_valid), 128'(1'b1));
      chk($sformatf("m%0d.busy[%0d]",  mode, idx), 128'(busy),     128'(1'b1));
      chk($sformatf("m%0d.done[%0d]",  mode, idx), 128'(done),     128'(1'b0));
      chk($sformatf("m%0d.data[%0d]",  mode, idx), 128'(tx_data),  128'(byte_of(blk, idx)));
      if (mode == 3 && idx == 9) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.valid", 128'(tx_valid), 128'(1'b0));
        chk("rst_mid.busy",  128'(busy),     128'(1'b0));
        chk("rst_mid.done",  128'(done),     128'(1'b0));
        chk("rst_mid.data",  128'(tx_data),  128'(8'h00));
        return;
      end
      rdy = 1'b1;
      if (mode == 1) begin
        if (idx == 7 && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = alt;
          alt = ~alt;
        end
      end
      if (mode == 2 && idx == 4) begin
        load        = 1'b1;
        parallel_in = {128{1'b1}};
      end
      tx_ready = rdy;
      if (rdy) idx++;
    end
    chk($sformatf("m%0d.timeout", mode), 128'(idx), 128'(16));
    @(negedge clk);
    load = 1'b0;
    chk_idle($sformatf("m%0d.done_cyc", mode), 1'b1, byte_of(blk, 15));
    if (load_next) begin
      start(next_blk);
    end else begin
      @(negedge clk);
      chk_idle($sformatf("m%0d.after", mode), 1'b0, byte_of(blk, 15));
    end
  endtask

  typedef struct {
    logic         ld;
    logic [127:0] din;
    logic         rdy;
    logic         ev;
    logic         eb;
    logic         ed;
    logic [7:0]   edata;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Full-rate vectors: inputs applied at one falling edge, outputs expected at the next
    for (int k = 0; k < 18; k++) begin
      tbl[k].ld  = (k == 0);
      tbl[k].din = (k == 0) ? BLK_A : '0;
      tbl[k].rdy = 1'b1;
      tbl[k].ev  = (k < 16);
      tbl[k].eb  = (k < 16);
      tbl[k].ed  = (k == 16);
      tbl[k].edata = (k < 16) ? 8'(k) : 8'h0F;
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk_idle("rst", 1'b0, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i), 1'b0, 8'h00);
    end

    // Full-rate transfer from the vector table
    for (int k = 0; k < 18; k++) begin
      load        = tbl[k].ld;
      parallel_in = tbl[k].din;
      tx_ready    = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("tbl.valid[%0d]", k), 128'(tx_valid), 128'(tbl[k].ev));
      chk($sformatf("tbl.busy[%0d]",  k), 128'(busy),     128'(tbl[k].eb));
      chk($sformatf("tbl.done[%0d]",  k), 128'(done),     128'(tbl[k].ed));
      chk($sformatf("tbl.data[%0d]",  k), 128'(tx_data),  128'(tbl[k].edata));
    end
    load = 1'b0;

    // Backpressure with a 5-cycle stall on byte 7
    start(BLK_A);
    drain(BLK_A, 1, 1'b0, '0);

    // Load while busy must be ignored
    start(BLK_A);
    drain(BLK_A, 2, 1'b0, '0);
    repeat (3) begin
      @(negedge clk);
      chk_idle("no_second", 1'b0, 8'h0F);
    end

    // Asynchronous reset mid-transfer, then a fresh block
    start(BLK_A);
    drain(BLK_A, 3, 1'b0, '0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk_idle("rst_hold", 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel", 1'b0, 8'h00);
    start(BLK_A5);
    drain(BLK_A5, 0, 1'b0, '0);

    // Back-to-back blocks with loopback into the SIPO model
    start(BLK_A);
    drain(BLK_A, 0, 1'b1, BLK_B);
    sipo_clr = 1'b1;
    @(negedge clk);
    sipo_clr = 1'b0;
    sipo_en  = 1'b1;
    load     = 1'b0;
    chk("b2b.valid", 128'(tx_valid), 128'(1'b1));
    chk("b2b.data0", 128'(tx_data),  128'(byte_of(BLK_B, 0)));
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("b2b.data[%0d]", i), 128'(tx_data), 128'(byte_of(BLK_B, i)));
    end
    @(negedge clk);
    chk_idle("b2b.done", 1'b1, byte_of(BLK_B, 15));
    chk("sipo.full", 128'(sipo_cnt == 16), 128'(1'b1));
    chk("sipo.data", sipo_q, BLK_B);
    sipo_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
